// File: rtl/viterbi_ber_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_ber_pkg
// Purpose  : Shared types, default thresholds and helpers for the post-Viterbi
//            bit-error-rate checker.
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_ber_pkg;

    // Checker state: waiting for data, hunting for the latency, tracking it
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } ber_state_t;

    // Default lock/unlock thresholds
    localparam int unsigned C_LOCK_RUN   = 16;
    localparam int unsigned C_WIN        = 64;
    localparam int unsigned C_UNLOCK_ERR = 8;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    // Operates on a 64-bit container; callers cast back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                            input int unsigned width);
        logic [63:0] max_v;
        if (width >= 64) begin
            max_v = '1;
        end else begin
            max_v = (64'd1 << width) - 64'd1;
        end
        if (val >= max_v) begin
            return val;
        end
        return val + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_ref_hist.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_ref_hist
// Purpose  : Reference-bit history for the BER checker. Holds the last DEPTH
//            accepted encoder-input bits, counts how many are valid, and
//            offers a single indexed read port.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_ref_hist #(
    parameter int DEPTH = 64,
    parameter int LAT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_valid_i,
    input  logic             ref_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic             hist_bit_o,
    output logic             avail_o
);

    // One extra bit so the fill count can reach DEPTH itself
    localparam int FILL_W = LAT_W + 1;

    logic [DEPTH-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Shift a new bit in at index 0; index k is then the bit from k+1 strobes ago
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (ref_valid_i) begin
            hist_d = {hist_q[DEPTH-2:0], ref_i};
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // History and fill registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Read uses the registered (pre-shift) history
    assign hist_bit_o = hist_q[lat_i];
    // The tap is meaningful only once more than 'lat' bits have been seen
    assign avail_o    = ({1'b0, lat_i} < fill_q);

endmodule
`default_nettype wire

// File: rtl/viterbi_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_ber_checker
// Purpose  : Compares decoded bits against the delayed encoder input, finds
//            the decoder latency automatically, then counts compared bits and
//            residual errors while locked.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_ber_checker
    import viterbi_ber_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int LAT_W      = 6,
    parameter int CNT_W      = 32,
    parameter int LOCK_RUN   = C_LOCK_RUN,
    parameter int WIN        = C_WIN,
    parameter int UNLOCK_ERR = C_UNLOCK_ERR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ref_valid_i,
    input  logic             ref_i,
    input  logic             dec_valid_i,
    input  logic             dec_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic [LAT_W-1:0] lat_o,
    output logic [CNT_W-1:0] bit_ct_o,
    output logic [CNT_W-1:0] err_ct_o,
    output logic             lock_loss_o
);

    localparam int RUN_W  = $clog2(LOCK_RUN) + 1;
    localparam int WCT_W  = $clog2(WIN) + 1;
    localparam int WERR_W = $clog2(UNLOCK_ERR + 1) + 1;

    ber_state_t        state_q, state_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WCT_W-1:0]  win_ct_q, win_ct_d;
    logic [WERR_W-1:0] win_err_q, win_err_d;
    logic [CNT_W-1:0]  bit_ct_q, bit_ct_d;
    logic [CNT_W-1:0]  err_ct_q, err_ct_d;
    logic              locked_q, locked_d;
    logic              lock_loss_q, lock_loss_d;

    logic              w_hist_bit;
    logic              w_avail;
    logic              w_dec;
    logic              w_match;
    logic              w_cmp;
    logic [LAT_W-1:0]  w_lat_next;
    ber_state_t        w_eff_state;
    logic [WERR_W-1:0] w_win_err_sum;

    viterbi_ref_hist #(
        .DEPTH (DEPTH),
        .LAT_W (LAT_W)
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid_i),
        .ref_i       (ref_i),
        .lat_i       (lat_q),
        .hist_bit_o  (w_hist_bit),
        .avail_o     (w_avail)
    );

    // Gate the decoded bit so an undriven dec_i cannot leak into the compare
    assign w_dec      = dec_valid_i & dec_i;
    assign w_match    = (w_dec == w_hist_bit);
    assign w_cmp      = dec_valid_i & w_avail;
    assign w_lat_next = (lat_q == LAT_W'(DEPTH - 1)) ? '0 : lat_q + 1'b1;

    // Next-state, latency search, window tracking and counters
    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        run_d         = run_q;
        win_ct_d      = win_ct_q;
        win_err_d     = win_err_q;
        bit_ct_d      = bit_ct_q;
        err_ct_d      = err_ct_q;
        locked_d      = locked_q;
        lock_loss_d   = 1'b0;
        w_eff_state   = state_q;
        w_win_err_sum = win_err_q + WERR_W'(!w_match);

        // The very first decoded strobe is already judged by search rules
        if (dec_valid_i && (state_q == IDLE)) begin
            state_d     = SEARCH;
            w_eff_state = SEARCH;
        end

        if (w_cmp) begin
            case (w_eff_state)
                SEARCH: begin
                    if (w_match) begin
                        if (run_q == RUN_W'(LOCK_RUN - 1)) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            run_d     = '0;
                            win_ct_d  = '0;
                            win_err_d = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                        lat_d = w_lat_next;
                    end
                end
                LOCKED: begin
                    bit_ct_d  = CNT_W'(sat_inc(64'(bit_ct_q), CNT_W));
                    win_ct_d  = win_ct_q + 1'b1;
                    win_err_d = w_win_err_sum;
                    if (!w_match) begin
                        err_ct_d = CNT_W'(sat_inc(64'(err_ct_q), CNT_W));
                    end
                    // Loss check sees this sample's error before any window restart
                    if (w_win_err_sum == WERR_W'(UNLOCK_ERR)) begin
                        state_d     = SEARCH;
                        locked_d    = 1'b0;
                        lock_loss_d = 1'b1;
                        lat_d       = w_lat_next;
                        run_d       = '0;
                    end else if (win_ct_q == WCT_W'(WIN - 1)) begin
                        win_ct_d  = '0;
                        win_err_d = '0;
                    end
                end
                default: begin
                end
            endcase
        end

        // Clear takes priority over any count from a coincident compare
        if (clear_i) begin
            bit_ct_d = '0;
            err_ct_d = '0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            run_q       <= '0;
            win_ct_q    <= '0;
            win_err_q   <= '0;
            bit_ct_q    <= '0;
            err_ct_q    <= '0;
            locked_q    <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            run_q       <= run_d;
            win_ct_q    <= win_ct_d;
            win_err_q   <= win_err_d;
            bit_ct_q    <= bit_ct_d;
            err_ct_q    <= err_ct_d;
            locked_q    <= locked_d;
            lock_loss_q <= lock_loss_d;
        end
    end

    assign locked_o    = locked_q;
    assign lat_o       = lat_q;
    assign bit_ct_o    = bit_ct_q;
    assign err_ct_o    = err_ct_q;
    assign lock_loss_o = lock_loss_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_ber_checker
// Purpose  : Directed self-checking bench for viterbi_ber_checker. A second
//            instance with 4-bit counters and a high unlock threshold is used
//            for the saturation and clear scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_ber_checker;

    logic       clk;
    logic       rst;
    logic       ref_valid_i;
    logic       ref_i;
    logic       dec_valid_i;
    logic       dec_i;
    logic       clear_i;

    logic        locked_o;
    logic [5:0]  lat_o;
    logic [31:0] bit_ct_o;
    logic [31:0] err_ct_o;
    logic        lock_loss_o;

    logic        locked4;
    logic [5:0]  lat4;
    logic [3:0]  bit4;
    logic [3:0]  err4;
    logic        loss4;

    int   n_tests;
    int   n_fail;
    int   loss_pulses;
    logic refs[$];

    viterbi_ber_checker u_dut (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid_i),
        .ref_i       (ref_i),
        .dec_valid_i (dec_valid_i),
        .dec_i       (dec_i),
        .clear_i     (clear_i),
        .locked_o    (locked_o),
        .lat_o       (lat_o),
        .bit_ct_o    (bit_ct_o),
        .err_ct_o    (err_ct_o),
        .lock_loss_o (lock_loss_o)
    );

    viterbi_ber_checker #(
        .CNT_W      (4),
        .UNLOCK_ERR (32)
    ) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .ref_valid_i (ref_valid_i),
        .ref_i       (ref_i),
        .dec_valid_i (dec_valid_i),
        .dec_i       (dec_i),
        .clear_i     (clear_i),
        .locked_o    (locked4),
        .lat_o       (lat4),
        .bit_ct_o    (bit4),
        .err_ct_o    (err4),
        .lock_loss_o (loss4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count loss pulses of the main instance, sampled mid-cycle
    always @(negedge clk) begin
        if (lock_loss_o === 1'b1) loss_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Period-8 square wave: bit t and bit t+4 always differ
    function automatic logic sq(input int t);
        return t[2];
    endfunction

    task automatic push_ref(input logic r);
        ref_valid_i = 1'b1;
        ref_i       = r;
        @(posedge clk);
        #1;
        ref_valid_i = 1'b0;
        refs.push_back(r);
    endtask

    task automatic send_dec(input logic d, input logic clr);
        dec_valid_i = 1'b1;
        dec_i       = d;
        clear_i     = clr;
        @(posedge clk);
        #1;
        dec_valid_i = 1'b0;
        dec_i       = 1'bx;
        clear_i     = 1'b0;
    endtask

    // One reference bit, then one decoded bit taken 'dly' history slots back
    task automatic pair(input logic r, input int dly, input logic flip);
        logic d;
        push_ref(r);
        d = refs[refs.size() - 1 - dly];
        send_dec(d ^ flip, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (locked_o !== 1'b0 || lock_loss_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: locked=%0b loss=%0b expected 0 0", locked_o, lock_loss_o);
        end
        n_tests++;
        if (lat_o !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_lat: got %0d expected 0", lat_o);
        end
        n_tests++;
        if (bit_ct_o !== 32'd0 || err_ct_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: bit=%0d err=%0d expected 0 0", bit_ct_o, err_ct_o);
        end
    endtask

    // Decoded sample j equals reference bit j; bits 1..5 = 0 and bit 6 = 1
    // force a mismatch at lat 0..4, then lat 5 matches from sample 6 on.
    task automatic test_delay5();
        logic r;
        for (int n = 1; n <= 205; n++) begin
            if (n <= 5)      r = 1'b0;
            else if (n == 6) r = 1'b1;
            else             r = 1'($urandom_range(0, 1));
            push_ref(r);
            if (n >= 6) send_dec(refs[refs.size() - 6], 1'b0);
            if (n == 10) begin
                n_tests++;
                if (lat_o !== 6'd5 || locked_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL d5_search_lat: lat=%0d locked=%0b expected 5 0", lat_o, locked_o);
                end
            end
            if (n == 25) begin
                n_tests++;
                if (locked_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL d5_not_yet_locked: locked=%0b expected 0", locked_o);
                end
            end
            if (n == 26) begin
                n_tests++;
                if (locked_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL d5_lock_on_16th: locked=%0b expected 1", locked_o);
                end
            end
        end
        n_tests++;
        if (lat_o !== 6'd5 || locked_o !== 1'b1) begin
            n_fail++;
            $display("FAIL d5_final_lock: lat=%0d locked=%0b expected 5 1", lat_o, locked_o);
        end
        n_tests++;
        if (bit_ct_o !== 32'd179 || err_ct_o !== 32'd0) begin
            n_fail++;
            $display("FAIL d5_counts: bit=%0d err=%0d expected 179 0", bit_ct_o, err_ct_o);
        end
    endtask

    task automatic test_single_errors();
        bit   dropped;
        int   pulses0;
        dropped = 1'b0;
        pulses0 = loss_pulses;
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        n_tests++;
        if (bit_ct_o !== 32'd0 || err_ct_o !== 32'd0) begin
            n_fail++;
            $display("FAIL se_clear: bit=%0d err=%0d expected 0 0", bit_ct_o, err_ct_o);
        end
        for (int i = 0; i < 256; i++) begin
            pair(1'($urandom_range(0, 1)), 5, (i % 16) == 15);
            if (locked_o !== 1'b1) dropped = 1'b1;
        end
        n_tests++;
        if (dropped || loss_pulses != pulses0) begin
            n_fail++;
            $display("FAIL se_lock_held: dropped=%0b pulses=%0d expected 0 %0d", dropped, loss_pulses, pulses0);
        end
        n_tests++;
        if (bit_ct_o !== 32'd256 || err_ct_o !== 32'd16) begin
            n_fail++;
            $display("FAIL se_counts: bit=%0d err=%0d expected 256 16", bit_ct_o, err_ct_o);
        end
    endtask

    // Window holds 4 errors from the previous scenario; 4 more mismatches
    // at offset 9 (always wrong at lat 5 for the square wave) force loss.
    task automatic test_loss_of_lock();
        int         tt;
        int         pulses0;
        int         code;
        logic [5:0] last;
        bit         got_lock;
        tt      = 0;
        pulses0 = loss_pulses;
        for (int k = 0; k < 12; k++) begin
            push_ref(sq(tt));
            tt++;
        end
        for (int k = 0; k < 3; k++) begin
            pair(sq(tt), 9, 1'b0);
            tt++;
        end
        n_tests++;
        if (locked_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ll_pre_loss: locked=%0b expected 1", locked_o);
        end
        pair(sq(tt), 9, 1'b0);
        tt++;
        n_tests++;
        if (lock_loss_o !== 1'b1 || locked_o !== 1'b0 || lat_o !== 6'd6) begin
            n_fail++;
            $display("FAIL ll_loss: pulse=%0b locked=%0b lat=%0d expected 1 0 6", lock_loss_o, locked_o, lat_o);
        end
        n_tests++;
        if (bit_ct_o !== 32'd260 || err_ct_o !== 32'd20) begin
            n_fail++;
            $display("FAIL ll_counts_at_loss: bit=%0d err=%0d expected 260 20", bit_ct_o, err_ct_o);
        end
        last     = lat_o;
        code     = 0;
        got_lock = 1'b0;
        for (int k = 0; k < 80 && !got_lock; k++) begin
            pair(sq(tt), 9, 1'b0);
            tt++;
            if (lat_o !== last) begin
                code = code * 16 + int'(lat_o);
                last = lat_o;
            end
            if (locked_o === 1'b1) got_lock = 1'b1;
        end
        n_tests++;
        if (!got_lock || lat_o !== 6'd9 || code != 'h789) begin
            n_fail++;
            $display("FAIL ll_relock: locked=%0b lat=%0d walk=%0h expected 1 9 789", got_lock, lat_o, code);
        end
        n_tests++;
        if (bit_ct_o !== 32'd260 || err_ct_o !== 32'd20 || loss_pulses != pulses0 + 1) begin
            n_fail++;
            $display("FAIL ll_retained: bit=%0d err=%0d pulses=%0d expected 260 20 %0d",
                     bit_ct_o, err_ct_o, loss_pulses, pulses0 + 1);
        end
    endtask

    task automatic test_wrap();
        int         tt;
        int         code;
        logic [5:0] last;
        bit         got_lock;
        apply_reset();
        tt = 0;
        for (int k = 0; k < 64; k++) begin
            push_ref(sq(tt));
            tt++;
        end
        for (int l = 0; l < 62; l++) begin
            push_ref(sq(tt));
            tt++;
            send_dec(~refs[refs.size() - 1 - l], 1'b0);
        end
        n_tests++;
        if (lat_o !== 6'd62 || locked_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_start: lat=%0d locked=%0b expected 62 0", lat_o, locked_o);
        end
        last     = lat_o;
        code     = 0;
        got_lock = 1'b0;
        for (int k = 0; k < 80 && !got_lock; k++) begin
            pair(sq(tt), 2, 1'b0);
            tt++;
            if (lat_o !== last) begin
                code = code * 100 + int'(lat_o);
                last = lat_o;
            end
            if (locked_o === 1'b1) got_lock = 1'b1;
        end
        n_tests++;
        if (!got_lock || lat_o !== 6'd2 || code != 63000102) begin
            n_fail++;
            $display("FAIL wr_walk: locked=%0b lat=%0d walk=%0d expected 1 2 63000102", got_lock, lat_o, code);
        end
    endtask

    task automatic test_clear_sat();
        apply_reset();
        for (int k = 0; k < 16; k++) pair(1'($urandom_range(0, 1)), 0, 1'b0);
        n_tests++;
        if (locked4 !== 1'b1 || bit4 !== 4'd0) begin
            n_fail++;
            $display("FAIL cs_lock: locked=%0b bit=%0d expected 1 0", locked4, bit4);
        end
        for (int k = 0; k < 15; k++) pair(1'($urandom_range(0, 1)), 0, 1'b1);
        n_tests++;
        if (bit4 !== 4'd15 || err4 !== 4'd15) begin
            n_fail++;
            $display("FAIL cs_reach_max: bit=%0d err=%0d expected 15 15", bit4, err4);
        end
        for (int k = 0; k < 5; k++) pair(1'($urandom_range(0, 1)), 0, 1'b1);
        n_tests++;
        if (bit4 !== 4'd15 || err4 !== 4'd15 || locked4 !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_saturate: bit=%0d err=%0d locked=%0b expected 15 15 1", bit4, err4, locked4);
        end
        push_ref(1'($urandom_range(0, 1)));
        send_dec(~refs[refs.size() - 1], 1'b1);
        n_tests++;
        if (bit4 !== 4'd0 || err4 !== 4'd0 || locked4 !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_clear_wins: bit=%0d err=%0d locked=%0b expected 0 0 1", bit4, err4, locked4);
        end
    endtask

    task automatic test_reset_mid();
        int         tt;
        int         code;
        logic [5:0] last;
        bit         got_lock;
        apply_reset();
        tt = 0;
        for (int k = 0; k < 8; k++) begin
            push_ref(sq(tt));
            tt++;
        end
        got_lock = 1'b0;
        for (int k = 0; k < 60 && !got_lock; k++) begin
            pair(sq(tt), 3, 1'b0);
            tt++;
            if (locked_o === 1'b1) got_lock = 1'b1;
        end
        for (int k = 0; k < 5; k++) begin
            pair(sq(tt), 3, 1'b0);
            tt++;
        end
        n_tests++;
        if (!got_lock || lat_o !== 6'd3 || bit_ct_o !== 32'd5) begin
            n_fail++;
            $display("FAIL rm_pre: locked=%0b lat=%0d bit=%0d expected 1 3 5", got_lock, lat_o, bit_ct_o);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (locked_o !== 1'b0 || lat_o !== 6'd0 || bit_ct_o !== 32'd0 || err_ct_o !== 32'd0 || lock_loss_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_async: locked=%0b lat=%0d bit=%0d err=%0d loss=%0b expected all 0",
                     locked_o, lat_o, bit_ct_o, err_ct_o, lock_loss_o);
        end
        @(negedge clk);
        rst = 1'b0;
        tt  = 0;
        for (int k = 0; k < 8; k++) begin
            push_ref(sq(tt));
            tt++;
        end
        last     = lat_o;
        code     = 0;
        got_lock = 1'b0;
        for (int k = 0; k < 60 && !got_lock; k++) begin
            pair(sq(tt), 3, 1'b0);
            tt++;
            if (lat_o !== last) begin
                code = code * 16 + int'(lat_o);
                last = lat_o;
            end
            if (locked_o === 1'b1) got_lock = 1'b1;
        end
        n_tests++;
        if (!got_lock || lat_o !== 6'd3 || code != 'h123) begin
            n_fail++;
            $display("FAIL rm_relock: locked=%0b lat=%0d walk=%0h expected 1 3 123", got_lock, lat_o, code);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        loss_pulses = 0;
        rst         = 1'b1;
        ref_valid_i = 1'b0;
        ref_i       = 1'b0;
        dec_valid_i = 1'b0;
        dec_i       = 1'bx;
        clear_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_delay5();
        test_single_errors();
        test_loss_of_lock();
        test_wrap();
        test_clear_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
